// File: rtl/pipeline_ctrl_pkg.sv
// Shared opcodes, parser states, encodings and width helpers
// for the frame-synchronised compositing control bank.
package pipeline_ctrl_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_MODE    = 4'h1;
  localparam logic [3:0] OP_SCALE   = 4'h2;
  localparam logic [3:0] OP_OFFX    = 4'h3;
  localparam logic [3:0] OP_OFFY    = 4'h4;
  localparam logic [3:0] OP_OPAC    = 4'h5;
  localparam logic [3:0] OP_CLIP_L  = 4'h6;
  localparam logic [3:0] OP_CLIP_R  = 4'h7;
  localparam logic [3:0] OP_CLIP_T  = 4'h8;
  localparam logic [3:0] OP_CLIP_B  = 4'h9;
  localparam logic [3:0] OP_FREEZE  = 4'hA;
  localparam logic [3:0] OP_COMMIT  = 4'hB;
  localparam logic [3:0] OP_CLR_ERR = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_DISCARD
  } parse_state_e;

  localparam logic [1:0] OVL_NONE    = 2'd0;
  localparam logic [1:0] OVL_CHROMA  = 2'd1;
  localparam logic [1:0] OVL_DIRECT  = 2'd2;
  localparam logic [1:0] OVL_INVALID = 2'd3;

  localparam logic [1:0] RST_MODE  = OVL_NONE;
  localparam logic [1:0] RST_SCALE = 2'd0;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  layer;
    logic [15:0] val;
  } ctrl_wr_t;

  function automatic int off_w(input int prec);
    return prec + 1;
  endfunction

  function automatic int clip_w(input int prec);
    return prec;
  endfunction

  function automatic int opac_w(input int tp);
    return tp + 1;
  endfunction

  function automatic int opac_max(input int tp);
    return 1 << tp;
  endfunction

  function automatic logic [1:0] data_bytes(input logic [3:0] op);
    case (op)
      OP_MODE, OP_SCALE,
      OP_OPAC, OP_FREEZE: return 2'd1;
      OP_OFFX, OP_OFFY,
      OP_CLIP_L, OP_CLIP_R,
      OP_CLIP_T, OP_CLIP_B: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic is_reserved(input logic [3:0] op);
    return op > OP_CLR_ERR;
  endfunction

  function automatic logic needs_layer(input logic [3:0] op);
    return (op >= OP_MODE) && (op <= OP_CLIP_B);
  endfunction

endpackage

// File: rtl/ctrl_cmd_parser.sv
// SPI command parser: header/data assembly, validation, write strobe.
// In: clk, rst, byte_in/byte_valid, ss_active. Out: wr_stb+wr, err_stb.
module ctrl_cmd_parser
  import pipeline_ctrl_pkg::*;
#(
  parameter int LAYERS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       ss_active,
  output logic       wr_stb,
  output ctrl_wr_t   wr,
  output logic       err_stb
);

  parse_state_e state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [3:0]   layer_q, layer_d;
  logic [7:0]   hi_q, hi_d;

  logic       vld;
  logic [3:0] hdr_op;
  logic [3:0] hdr_ly;
  logic       hdr_bad;

  assign vld    = byte_valid & ss_active;
  assign hdr_op = byte_in[7:4];
  assign hdr_ly = byte_in[3:0];
  assign hdr_bad = is_reserved(hdr_op) ||
                   (needs_layer(hdr_op) &&
                    (int'(hdr_ly) >= LAYERS));

  // Strobes are decoded from the byte in flight so the
  // bank registers them on the very next edge.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    layer_d = layer_q;
    hi_d    = hi_q;
    wr_stb  = 1'b0;
    wr      = '0;
    err_stb = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (vld) begin
          if (hdr_bad) begin
            err_stb = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            op_d    = hdr_op;
            layer_d = hdr_ly;
            hi_d    = 8'h00;
            case (data_bytes(hdr_op))
              2'd2: state_d = ST_DATA_HI;
              2'd1: state_d = ST_DATA_LO;
              default: begin
                wr_stb   = (hdr_op != OP_NOP);
                wr.op    = hdr_op;
                wr.layer = hdr_ly;
              end
            endcase
          end
        end
      end
      ST_DATA_HI: begin
        if (!ss_active) begin
          state_d = ST_IDLE;
        end else if (vld) begin
          hi_d    = byte_in;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (!ss_active) begin
          state_d = ST_IDLE;
        end else if (vld) begin
          if (op_q == OP_MODE &&
              byte_in[1:0] == OVL_INVALID) begin
            err_stb = 1'b1;
            state_d = ST_DISCARD;
          end else begin
            wr_stb   = 1'b1;
            wr.op    = op_q;
            wr.layer = layer_q;
            wr.val   = {hi_q, byte_in};
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (!ss_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      layer_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      layer_q <= layer_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: rtl/multilayer_pipeline_control.sv
// Shadow/active control banks for LAYERS foreground layers, frame-synced
// commit, freeze, sticky error and MISO status byte.
module multilayer_pipeline_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int PRECISION              = 11,
  parameter int LAYERS                 = 2,
  parameter int TRANSPARENCY_PRECISION = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] spi_byte_in,
  input  logic       spi_byte_valid,
  input  logic       spi_ss_active,
  input  logic       frame_sync,
  output logic [7:0] spi_byte_out,
  output logic [2*LAYERS-1:0] ctrl_overlay_mode,
  output logic [2*LAYERS-1:0] ctrl_fg_scale,
  output logic [(PRECISION+1)*LAYERS-1:0] ctrl_fg_offset_x,
  output logic [(PRECISION+1)*LAYERS-1:0] ctrl_fg_offset_y,
  output logic [(TRANSPARENCY_PRECISION+1)*LAYERS-1:0]
               ctrl_fg_opacity,
  output logic [PRECISION*LAYERS-1:0] ctrl_fg_clip_left,
  output logic [PRECISION*LAYERS-1:0] ctrl_fg_clip_right,
  output logic [PRECISION*LAYERS-1:0] ctrl_fg_clip_top,
  output logic [PRECISION*LAYERS-1:0] ctrl_fg_clip_bottom,
  output logic ctrl_fg_freeze,
  output logic commit_pending,
  output logic cmd_error
);

  localparam int OW = off_w(PRECISION);
  localparam int CW = clip_w(PRECISION);
  localparam int TW = opac_w(TRANSPARENCY_PRECISION);
  localparam int OPQ_MAX = opac_max(TRANSPARENCY_PRECISION);
  localparam logic [TW-1:0] OPQ_RST = TW'(OPQ_MAX);
  localparam logic [15:0]   OPQ_LIM = 16'(OPQ_MAX);

  logic     wr_stb;
  logic     err_stb;
  ctrl_wr_t wr;
  int       lidx;

  ctrl_cmd_parser #(
    .LAYERS(LAYERS)
  ) u_parser (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (spi_byte_in),
    .byte_valid(spi_byte_valid),
    .ss_active (spi_ss_active),
    .wr_stb    (wr_stb),
    .wr        (wr),
    .err_stb   (err_stb)
  );

  assign lidx = int'(wr.layer);

  logic [2*LAYERS-1:0]  sh_mode_q,  sh_mode_d;
  logic [2*LAYERS-1:0]  sh_scale_q, sh_scale_d;
  logic [OW*LAYERS-1:0] sh_offx_q,  sh_offx_d;
  logic [OW*LAYERS-1:0] sh_offy_q,  sh_offy_d;
  logic [TW*LAYERS-1:0] sh_opac_q,  sh_opac_d;
  logic [CW*LAYERS-1:0] sh_clip_q [4];
  logic [CW*LAYERS-1:0] sh_clip_d [4];

  logic [2*LAYERS-1:0]  act_mode_q,  act_mode_d;
  logic [2*LAYERS-1:0]  act_scale_q, act_scale_d;
  logic [OW*LAYERS-1:0] act_offx_q,  act_offx_d;
  logic [OW*LAYERS-1:0] act_offy_q,  act_offy_d;
  logic [TW*LAYERS-1:0] act_opac_q,  act_opac_d;
  logic [CW*LAYERS-1:0] act_clip_q [4];
  logic [CW*LAYERS-1:0] act_clip_d [4];

  logic       frz_q, frz_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       cerr_q, cerr_d;
  logic [7:0] stat_q, stat_d;

  always_comb begin
    sh_mode_d   = sh_mode_q;
    sh_scale_d  = sh_scale_q;
    sh_offx_d   = sh_offx_q;
    sh_offy_d   = sh_offy_q;
    sh_opac_d   = sh_opac_q;
    sh_clip_d   = sh_clip_q;
    act_mode_d  = act_mode_q;
    act_scale_d = act_scale_q;
    act_offx_d  = act_offx_q;
    act_offy_d  = act_offy_q;
    act_opac_d  = act_opac_q;
    act_clip_d  = act_clip_q;
    frz_d  = frz_q;
    err_d  = err_q;
    cerr_d = err_stb;
    // A commit in flight consumes the pending flag; a B in the
    // same cycle re-arms it for the next frame.
    pend_d = pend_q & ~frame_sync;
    stat_d = {pend_q, frz_q, err_q, 5'b0};

    // Active takes the shadow as it stood before this cycle's write.
    if (frame_sync && pend_q) begin
      act_mode_d  = sh_mode_q;
      act_scale_d = sh_scale_q;
      act_offx_d  = sh_offx_q;
      act_offy_d  = sh_offy_q;
      act_opac_d  = sh_opac_q;
      act_clip_d  = sh_clip_q;
    end

    if (wr_stb) begin
      case (wr.op)
        OP_MODE:
          sh_mode_d[lidx*2 +: 2] = wr.val[1:0];
        OP_SCALE:
          sh_scale_d[lidx*2 +: 2] = wr.val[1:0];
        OP_OFFX:
          sh_offx_d[lidx*OW +: OW] = wr.val[OW-1:0];
        OP_OFFY:
          sh_offy_d[lidx*OW +: OW] = wr.val[OW-1:0];
        OP_OPAC:
          sh_opac_d[lidx*TW +: TW] =
            (wr.val > OPQ_LIM) ? OPQ_RST : wr.val[TW-1:0];
        OP_CLIP_L:
          sh_clip_d[0][lidx*CW +: CW] = wr.val[CW-1:0];
        OP_CLIP_R:
          sh_clip_d[1][lidx*CW +: CW] = wr.val[CW-1:0];
        OP_CLIP_T:
          sh_clip_d[2][lidx*CW +: CW] = wr.val[CW-1:0];
        OP_CLIP_B:
          sh_clip_d[3][lidx*CW +: CW] = wr.val[CW-1:0];
        OP_FREEZE:  frz_d  = wr.val[0];
        OP_COMMIT:  pend_d = 1'b1;
        OP_CLR_ERR: err_d  = 1'b0;
        default: ;
      endcase
    end

    if (err_stb) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode_q   <= {LAYERS{RST_MODE}};
      sh_scale_q  <= {LAYERS{RST_SCALE}};
      sh_offx_q   <= '0;
      sh_offy_q   <= '0;
      sh_opac_q   <= {LAYERS{OPQ_RST}};
      sh_clip_q   <= '{default: '0};
      act_mode_q  <= {LAYERS{RST_MODE}};
      act_scale_q <= {LAYERS{RST_SCALE}};
      act_offx_q  <= '0;
      act_offy_q  <= '0;
      act_opac_q  <= {LAYERS{OPQ_RST}};
      act_clip_q  <= '{default: '0};
      frz_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      cerr_q <= 1'b0;
      stat_q <= 8'h00;
    end else begin
      sh_mode_q   <= sh_mode_d;
      sh_scale_q  <= sh_scale_d;
      sh_offx_q   <= sh_offx_d;
      sh_offy_q   <= sh_offy_d;
      sh_opac_q   <= sh_opac_d;
      sh_clip_q   <= sh_clip_d;
      act_mode_q  <= act_mode_d;
      act_scale_q <= act_scale_d;
      act_offx_q  <= act_offx_d;
      act_offy_q  <= act_offy_d;
      act_opac_q  <= act_opac_d;
      act_clip_q  <= act_clip_d;
      frz_q  <= frz_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      cerr_q <= cerr_d;
      stat_q <= stat_d;
    end
  end

  assign ctrl_overlay_mode   = act_mode_q;
  assign ctrl_fg_scale       = act_scale_q;
  assign ctrl_fg_offset_x    = act_offx_q;
  assign ctrl_fg_offset_y    = act_offy_q;
  assign ctrl_fg_opacity     = act_opac_q;
  assign ctrl_fg_clip_left   = act_clip_q[0];
  assign ctrl_fg_clip_right  = act_clip_q[1];
  assign ctrl_fg_clip_top    = act_clip_q[2];
  assign ctrl_fg_clip_bottom = act_clip_q[3];
  assign ctrl_fg_freeze      = frz_q;
  assign commit_pending      = pend_q;
  assign cmd_error           = cerr_q;
  assign spi_byte_out        = stat_q;

endmodule

// File: tb/tb_multilayer_pipeline_control.sv
// Bench for multilayer_pipeline_control: directed vector table,
// hand-written reset sequence, randomized command stream vs model.
module tb_multilayer_pipeline_control;

  localparam int L  = 2;
  localparam int OW = 12;
  localparam int CW = 11;
  localparam int TW = 4;

  logic clk, rst;
  logic [7:0] spi_byte_in;
  logic spi_byte_valid, spi_ss_active, frame_sync;
  logic [7:0] spi_byte_out;
  logic [2*L-1:0] ctrl_overlay_mode, ctrl_fg_scale;
  logic [OW*L-1:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
  logic [TW*L-1:0] ctrl_fg_opacity;
  logic [CW*L-1:0] ctrl_fg_clip_left, ctrl_fg_clip_right;
  logic [CW*L-1:0] ctrl_fg_clip_top, ctrl_fg_clip_bottom;
  logic ctrl_fg_freeze, commit_pending, cmd_error;

  multilayer_pipeline_control #(
    .PRECISION(11),
    .LAYERS(L),
    .TRANSPARENCY_PRECISION(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi_byte_in(spi_byte_in),
    .spi_byte_valid(spi_byte_valid),
    .spi_ss_active(spi_ss_active),
    .frame_sync(frame_sync),
    .spi_byte_out(spi_byte_out),
    .ctrl_overlay_mode(ctrl_overlay_mode),
    .ctrl_fg_scale(ctrl_fg_scale),
    .ctrl_fg_offset_x(ctrl_fg_offset_x),
    .ctrl_fg_offset_y(ctrl_fg_offset_y),
    .ctrl_fg_opacity(ctrl_fg_opacity),
    .ctrl_fg_clip_left(ctrl_fg_clip_left),
    .ctrl_fg_clip_right(ctrl_fg_clip_right),
    .ctrl_fg_clip_top(ctrl_fg_clip_top),
    .ctrl_fg_clip_bottom(ctrl_fg_clip_bottom),
    .ctrl_fg_freeze(ctrl_fg_freeze),
    .commit_pending(commit_pending),
    .cmd_error(cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  task automatic drive(input bit ss, input bit vld,
                       input logic [7:0] b, input bit fs);
    @(negedge clk);
    spi_ss_active  = ss;
    spi_byte_valid = vld;
    spi_byte_in    = b;
    frame_sync     = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    spi_ss_active = 0; spi_byte_valid = 0;
    spi_byte_in = 0; frame_sync = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit ss; bit vld; logic [7:0] b; bit fs;
    bit e_cerr; logic [7:0] e_out; bit e_frz; bit e_pend;
    logic [11:0] e_ox1; logic [3:0] e_op0;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit ss, input bit vld,
                     input logic [7:0] b, input bit fs,
                     input bit cerr, input logic [7:0] out,
                     input bit frz, input bit pend,
                     input logic [11:0] ox1,
                     input logic [3:0] op0);
    vec_t v;
    v.ss = ss; v.vld = vld; v.b = b; v.fs = fs;
    v.e_cerr = cerr; v.e_out = out; v.e_frz = frz;
    v.e_pend = pend; v.e_ox1 = ox1; v.e_op0 = op0;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  m_sh_mode[L], m_act_mode[L];
  logic [1:0]  m_sh_scale[L], m_act_scale[L];
  logic [11:0] m_sh_ox[L], m_act_ox[L];
  logic [11:0] m_sh_oy[L], m_act_oy[L];
  logic [3:0]  m_sh_op[L], m_act_op[L];
  logic [10:0] m_sh_clip[L][4], m_act_clip[L][4];
  bit m_pend, m_frz, m_err, e_cerr;
  logic [7:0] e_out;

  task automatic model_reset();
    for (int l = 0; l < L; l++) begin
      m_sh_mode[l] = 0; m_act_mode[l] = 0;
      m_sh_scale[l] = 0; m_act_scale[l] = 0;
      m_sh_ox[l] = 0; m_act_ox[l] = 0;
      m_sh_oy[l] = 0; m_act_oy[l] = 0;
      m_sh_op[l] = 8; m_act_op[l] = 8;
      for (int c = 0; c < 4; c++) begin
        m_sh_clip[l][c] = 0; m_act_clip[l][c] = 0;
      end
    end
    m_pend = 0; m_frz = 0; m_err = 0;
    e_cerr = 0; e_out = 0;
  endtask

  // ev: 0 none, 1 accepted command, 2 rejected command
  task automatic model_step(input bit fs, input int ev,
                            input int op, input int layer,
                            input logic [15:0] val);
    e_out = {m_pend, m_frz, m_err, 5'b0};
    if (fs && m_pend) begin
      m_act_mode = m_sh_mode; m_act_scale = m_sh_scale;
      m_act_ox = m_sh_ox; m_act_oy = m_sh_oy;
      m_act_op = m_sh_op; m_act_clip = m_sh_clip;
    end
    if (fs) m_pend = 0;
    e_cerr = 0;
    if (ev == 2) begin
      m_err = 1; e_cerr = 1;
    end else if (ev == 1) begin
      case (op)
        1: m_sh_mode[layer] = val[1:0];
        2: m_sh_scale[layer] = val[1:0];
        3: m_sh_ox[layer] = val[11:0];
        4: m_sh_oy[layer] = val[11:0];
        5: m_sh_op[layer] = (val > 16'd8) ? 4'd8 : val[3:0];
        6, 7, 8, 9: m_sh_clip[layer][op-6] = val[10:0];
        10: m_frz = val[0];
        11: m_pend = 1;
        12: m_err = 0;
        default: ;
      endcase
    end
  endtask

  logic [2*L-1:0] x_mode, x_scale;
  logic [OW*L-1:0] x_ox, x_oy;
  logic [TW*L-1:0] x_op;
  logic [CW*L-1:0] x_clip[4];

  task automatic compare_all();
    for (int l = 0; l < L; l++) begin
      x_mode[l*2 +: 2] = m_act_mode[l];
      x_scale[l*2 +: 2] = m_act_scale[l];
      x_ox[l*OW +: OW] = m_act_ox[l];
      x_oy[l*OW +: OW] = m_act_oy[l];
      x_op[l*TW +: TW] = m_act_op[l];
      for (int c = 0; c < 4; c++)
        x_clip[c][l*CW +: CW] = m_act_clip[l][c];
    end
    chk("rnd_mode", ctrl_overlay_mode, x_mode);
    chk("rnd_scale", ctrl_fg_scale, x_scale);
    chk("rnd_offx", ctrl_fg_offset_x, x_ox);
    chk("rnd_offy", ctrl_fg_offset_y, x_oy);
    chk("rnd_opac", ctrl_fg_opacity, x_op);
    chk("rnd_clipl", ctrl_fg_clip_left, x_clip[0]);
    chk("rnd_clipr", ctrl_fg_clip_right, x_clip[1]);
    chk("rnd_clipt", ctrl_fg_clip_top, x_clip[2]);
    chk("rnd_clipb", ctrl_fg_clip_bottom, x_clip[3]);
    chk("rnd_freeze", ctrl_fg_freeze, m_frz);
    chk("rnd_pend", commit_pending, m_pend);
    chk("rnd_cmderr", cmd_error, e_cerr);
    chk("rnd_status", spi_byte_out, e_out);
  endtask

  task automatic rcyc(input bit ss, input bit vld,
                      input logic [7:0] b, input int ev,
                      input int op, input int layer,
                      input logic [15:0] val);
    bit fs;
    fs = ($urandom_range(0, 7) == 0);
    drive(ss, vld, b, fs);
    model_step(fs, ev, op, layer, val);
    compare_all();
  endtask

  task automatic send(input logic [7:0] b, input int ev,
                      input int op, input int layer,
                      input logic [15:0] val);
    repeat ($urandom_range(0, 2))
      rcyc(1, 0, 8'($urandom), 0, 0, 0, 0);
    rcyc(1, 1, b, ev, op, layer, val);
  endtask

  task automatic junk();
    repeat ($urandom_range(0, 2))
      send(8'($urandom), 0, 0, 0, 0);
  endtask

  task automatic transaction();
    int ncmd, op, layer, nb, k;
    bit stop, bad;
    logic [7:0] hdr;
    logic [15:0] val;
    ncmd = $urandom_range(1, 4);
    stop = 0;
    for (int c = 0; c < ncmd && !stop; c++) begin
      op = $urandom_range(0, 15);
      layer = ($urandom_range(0, 3) == 0) ?
              $urandom_range(2, 15) : $urandom_range(0, 1);
      if (op == 1 || op == 2 || op == 5 || op == 10) nb = 1;
      else if (op >= 3 && op <= 9) nb = 2;
      else nb = 0;
      bad = (op >= 13) || (op >= 1 && op <= 9 && layer >= L);
      hdr = {op[3:0], layer[3:0]};
      if (op == 1) val = 16'($urandom_range(0, 3));
      else if (op == 5)
        val = ($urandom_range(0, 3) == 0) ?
              16'($urandom_range(0, 255)) :
              16'($urandom_range(0, 12));
      else if (nb == 1) val = 16'($urandom_range(0, 255));
      else val = 16'($urandom);
      if (bad) begin
        send(hdr, 2, op, layer, 0);
        junk();
        stop = 1;
      end else if (nb == 0) begin
        send(hdr, (op == 0) ? 0 : 1, op, layer, 0);
      end else if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, nb - 1);
        send(hdr, 0, 0, 0, 0);
        if (k == 1) send(val[15:8], 0, 0, 0, 0);
        stop = 1;
      end else begin
        send(hdr, 0, 0, 0, 0);
        if (nb == 2) send(val[15:8], 0, 0, 0, 0);
        if (op == 1 && val[1:0] == 2'd3) begin
          send(val[7:0], 2, op, layer, val);
          junk();
          stop = 1;
        end else begin
          send(val[7:0], 1, op, layer, val);
        end
      end
    end
    repeat ($urandom_range(1, 2))
      rcyc(0, 1'($urandom), 8'($urandom), 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    spi_ss_active = 0; spi_byte_valid = 0;
    spi_byte_in = 0; frame_sync = 0;
    do_reset();

    chk("rst_mode", ctrl_overlay_mode, 0);
    chk("rst_scale", ctrl_fg_scale, 0);
    chk("rst_offx", ctrl_fg_offset_x, 0);
    chk("rst_offy", ctrl_fg_offset_y, 0);
    chk("rst_opac", ctrl_fg_opacity, 8'h88);
    chk("rst_clipl", ctrl_fg_clip_left, 0);
    chk("rst_clipr", ctrl_fg_clip_right, 0);
    chk("rst_clipt", ctrl_fg_clip_top, 0);
    chk("rst_clipb", ctrl_fg_clip_bottom, 0);
    chk("rst_freeze", ctrl_fg_freeze, 0);
    chk("rst_pend", commit_pending, 0);
    chk("rst_cmderr", cmd_error, 0);
    chk("rst_status", spi_byte_out, 8'h00);

    // ss vld byte fs | cerr out frz pend ox1 op0
    add(1,1,8'h31,0, 0,8'h00,0,0,12'h000,8);
    add(1,1,8'hFF,0, 0,8'h00,0,0,12'h000,8);
    add(1,1,8'h9C,0, 0,8'h00,0,0,12'h000,8);
    add(1,1,8'hB0,0, 0,8'h00,0,1,12'h000,8);
    add(1,0,8'h00,0, 0,8'h80,0,1,12'h000,8);
    add(1,0,8'h00,1, 0,8'h80,0,0,12'hF9C,8);
    add(0,0,8'h00,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h12,0, 1,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h50,0, 0,8'h20,0,0,12'hF9C,8);
    add(1,1,8'h1F,0, 0,8'h20,0,0,12'hF9C,8);
    add(0,0,8'h00,0, 0,8'h20,0,0,12'hF9C,8);
    add(1,1,8'hC0,0, 0,8'h20,0,0,12'hF9C,8);
    add(1,0,8'h00,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h60,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h01,0, 0,8'h00,0,0,12'hF9C,8);
    add(0,0,8'h00,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'hB0,0, 0,8'h00,0,1,12'hF9C,8);
    add(1,0,8'h00,1, 0,8'h80,0,0,12'hF9C,8);
    add(0,0,8'h00,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'hA0,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h01,0, 0,8'h00,1,0,12'hF9C,8);
    add(1,0,8'h00,0, 0,8'h40,1,0,12'hF9C,8);
    add(1,1,8'hA0,0, 0,8'h40,1,0,12'hF9C,8);
    add(1,1,8'h00,0, 0,8'h40,0,0,12'hF9C,8);
    add(1,0,8'h00,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h50,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h05,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'hB0,1, 0,8'h00,0,1,12'hF9C,8);
    add(1,0,8'h00,0, 0,8'h80,0,1,12'hF9C,8);
    add(1,0,8'h00,1, 0,8'h80,0,0,12'hF9C,5);
    add(1,1,8'h50,0, 0,8'h00,0,0,12'hF9C,5);
    add(1,1,8'h1F,0, 0,8'h00,0,0,12'hF9C,5);
    add(1,1,8'hB0,0, 0,8'h00,0,1,12'hF9C,5);
    add(1,0,8'h00,1, 0,8'h80,0,0,12'hF9C,8);
    add(1,1,8'h10,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'h03,0, 1,8'h00,0,0,12'hF9C,8);
    add(0,0,8'h00,0, 0,8'h20,0,0,12'hF9C,8);
    add(1,1,8'hC0,0, 0,8'h20,0,0,12'hF9C,8);
    add(1,0,8'h00,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'hB0,0, 0,8'h00,0,1,12'hF9C,8);
    add(1,1,8'h31,0, 0,8'h80,0,1,12'hF9C,8);
    add(1,1,8'h00,0, 0,8'h80,0,1,12'hF9C,8);
    add(1,1,8'h0A,1, 0,8'h80,0,0,12'hF9C,8);
    add(1,0,8'h00,0, 0,8'h00,0,0,12'hF9C,8);
    add(1,1,8'hB0,0, 0,8'h00,0,1,12'hF9C,8);
    add(1,0,8'h00,1, 0,8'h80,0,0,12'h00A,8);
    add(0,0,8'h00,0, 0,8'h00,0,0,12'h00A,8);

    foreach (tbl[i]) begin
      drive(tbl[i].ss, tbl[i].vld, tbl[i].b, tbl[i].fs);
      chk($sformatf("v%0d_cmderr", i), cmd_error, tbl[i].e_cerr);
      chk($sformatf("v%0d_status", i), spi_byte_out, tbl[i].e_out);
      chk($sformatf("v%0d_freeze", i), ctrl_fg_freeze, tbl[i].e_frz);
      chk($sformatf("v%0d_pend", i), commit_pending, tbl[i].e_pend);
      chk($sformatf("v%0d_offx1", i),
          ctrl_fg_offset_x[OW +: OW], tbl[i].e_ox1);
      chk($sformatf("v%0d_opac0", i),
          ctrl_fg_opacity[TW-1:0], tbl[i].e_op0);
      chk($sformatf("v%0d_clipl0", i),
          ctrl_fg_clip_left[CW-1:0], 0);
    end

    // Reset in the middle of a two-byte command.
    drive(1, 1, 8'hA0, 0);
    drive(1, 1, 8'h01, 0);
    drive(1, 1, 8'hF0, 0);
    drive(0, 0, 8'h00, 0);
    drive(1, 1, 8'hB0, 0);
    drive(1, 1, 8'h30, 0);
    drive(1, 1, 8'h12, 0);
    rst = 1'b1;
    drive(1, 1, 8'h34, 0);
    rst = 1'b0;
    chk("mid_rst_freeze", ctrl_fg_freeze, 0);
    chk("mid_rst_pend", commit_pending, 0);
    chk("mid_rst_status", spi_byte_out, 8'h00);
    chk("mid_rst_cmderr", cmd_error, 0);
    chk("mid_rst_opac", ctrl_fg_opacity, 8'h88);
    chk("mid_rst_offx1", ctrl_fg_offset_x, 0);
    drive(1, 1, 8'hB0, 0);
    chk("post_rst_idle_pend", commit_pending, 1);
    chk("post_rst_cmderr", cmd_error, 0);
    drive(1, 0, 8'h00, 0);
    chk("post_rst_status", spi_byte_out, 8'h80);
    drive(0, 0, 8'h00, 1);
    chk("post_rst_offx", ctrl_fg_offset_x, 0);

    // Randomized command stream against the model.
    do_reset();
    model_reset();
    repeat (400) transaction();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multilayer_pipeline_control.md
# multilayer_pipeline_control

Frame-synchronised control register bank for a multi-layer compositing pipeline. Generalises the single-foreground control path to `LAYERS` independent foreground layers. It parses byte-level commands from the SPI slave front-end into per-layer shadow registers and commits them to the live control buses only at a frame boundary, so a frame is never composited with half-updated settings. It sits between the SPI byte receiver and the pipeline instances' `ctrl_*` inputs.

## Interface
- `PRECISION`, 11, bits of an unsigned screen coordinate
- `LAYERS`, 2, number of foreground layers (1..16)
- `TRANSPARENCY_PRECISION`, 3, opacity field is `TRANSPARENCY_PRECISION+1` bits
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `spi_byte_in`  in  8  received command/data byte
- `spi_byte_valid`  in  1  one-cycle strobe, `spi_byte_in` valid
- `spi_ss_active`  in  1  high while an SPI transaction is open
- `frame_sync`  in  1  one-cycle pulse at the first cycle of vertical blanking
- `spi_byte_out`  out  8  status byte for MISO: `{commit_pending, ctrl_fg_freeze, err_sticky, 5'b0}`
- `ctrl_overlay_mode`  out  2*LAYERS  per layer: 0 none, 1 chroma key, 2 direct
- `ctrl_fg_scale`  out  2*LAYERS  per-layer scale code
- `ctrl_fg_offset_x`, `ctrl_fg_offset_y`  out  (PRECISION+1)*LAYERS each  signed offsets
- `ctrl_fg_opacity`  out  (TRANSPARENCY_PRECISION+1)*LAYERS  opacity
- `ctrl_fg_clip_left/right/top/bottom`  out  PRECISION*LAYERS each  clip amounts
- `ctrl_fg_freeze`  out  1  global foreground freeze, not frame-synchronised
- `commit_pending`  out  1  commit requested, awaiting `frame_sync`
- `cmd_error`  out  1  one-cycle pulse on a rejected command

Layer `n` occupies slice `[n*W +: W]` of each bus.

## Operation
- Command header byte: `[7:4]` opcode, `[3:0]` layer index.
- Opcodes and data bytes:
  - 0 NOP (0)
  - 1 overlay mode (1)
  - 2 scale (1)
  - 3 offset x (2)
  - 4 offset y (2)
  - 5 opacity (1)
  - 6–9 clip left/right/top/bottom (2)
  - A freeze (1, bit0)
  - B commit (0)
  - C clear sticky error (0)
  - D–F reserved
- Two-byte values are big-endian 16-bit. Store the low `PRECISION+1` bits for offsets (two's complement) and the low `PRECISION` bits for clips. One-byte values use the low bits.
- Opacity is saturating: data > 2^TRANSPARENCY_PRECISION stores 2^TRANSPARENCY_PRECISION.
- Parser FSM:
  - IDLE: on a header byte, go to DATA_HI, DATA_LO, or back to IDLE, depending on the opcode's byte count.
  - DATA_HI → DATA_LO → IDLE.
  - DISCARD: hold until `spi_ss_active` falls, then go to IDLE.
- Multiple commands per transaction are allowed back-to-back.
- Rejections: reserved opcode, layer index ≥ `LAYERS` (opcodes 1–9), or overlay mode data = 3.
  - Effect: pulse `cmd_error`, set `err_sticky`, make no register write, enter DISCARD.
  - Data-byte rejection (mode 3) is detected on that byte.
- `spi_ss_active` falling in DATA_HI/DATA_LO aborts the command: partial data is dropped, shadow is unchanged, FSM returns to IDLE.
- Writes 1–9 update only shadow registers. B sets `commit_pending`.
- On `frame_sync` with `commit_pending`: all active registers load all shadow values (every layer), and `commit_pending` clears.
- A (freeze) writes `ctrl_fg_freeze` directly.
- C clears `err_sticky`.

## Timing
- Reset values, shadow and active alike:
  - overlay mode 0, scale 0, offsets 0
  - opacity 2^TRANSPARENCY_PRECISION
  - clips 0
  - `ctrl_fg_freeze` 0, `commit_pending` 0, `cmd_error` 0, `err_sticky` 0
  - `spi_byte_out` 8'h00, FSM IDLE
- `rst` mid-command aborts it and restores all reset values the next cycle.
- Shadow write: takes effect the cycle after the final byte's `spi_byte_valid`.
- Freeze: `ctrl_fg_freeze` changes the cycle after the A data byte.
- `commit_pending`: set the cycle after the B byte.
- Commit: active buses change the cycle after `frame_sync`.
- `spi_byte_out`: registered from current status, 1-cycle latency.
- Simultaneous events:
  - B in the same cycle as `frame_sync`: no commit this frame; pending is set and applied at the next `frame_sync`.
  - Shadow write completing in the same cycle as a committing `frame_sync`: active takes the pre-write shadow value; the new value waits for the next commit.
  - C and a rejection in the same cycle cannot occur (one byte per cycle).
- `spi_byte_valid` is ignored while `spi_ss_active` is low.

## Structure
- Shared package `pipeline_ctrl_pkg` holds:
  - opcode constants
  - parser state enum
  - overlay mode encodings
  - reset-value constants
  - the per-layer slice-width helpers
- Sub-module `ctrl_cmd_parser` contains the FSM, byte assembly and validation. It emits a one-cycle write strobe with `{opcode, layer, value16}`.
- The top level holds the shadow/active banks, commit logic and status byte.

## Test plan
- Reset, then read all buses → opacity = 8 for every layer (TP=3), all else 0, `spi_byte_out` = 0x00.
- Bytes 0x31, 0xFF, 0x9C, 0xB0, then `frame_sync` → layer1 `ctrl_fg_offset_x` = 12'hF9C (−100) one cycle after sync; unchanged before sync.
- Header 0x12 with `LAYERS`=2 → `cmd_error` pulse, `spi_byte_out` = 0x20; following bytes ignored until SS falls; C command → 0x00.
- 0x60, 0x01, then SS falls, then `frame_sync` with pending → clip left unchanged (0).
- 0x50, 0x1F → shadow opacity 8. B asserted in the same cycle as `frame_sync` → no change; next `frame_sync` → committed.
- 0xA0, 0x01 → `ctrl_fg_freeze` = 1 the next cycle with no `frame_sync`; status = 0x40.
